// File: rtl/commit_ctrl.sv
// commit_ctrl: commit-stage sequencer between the ROB head and the
// architectural register file. Retires at most one head entry per cycle,
// drives the register-file write port, handshakes stores with the LSB,
// redirects fetch and flushes the pipeline on a branch mispredict, and stops
// permanently on a HALT entry.
//
// Ports:
//   clk_in, rst_in (sync, active high), rdy_in (global enable / freeze)
//   head_*            : ROB head entry (valid, done, tag, kind, rd, val, pc,
//                       mispredict, target)
//   store_done        : LSB has completed the committed store
//   head_pop          : combinational retire strobe back to the ROB
//   write_rdy/rd/write_val : register-file write port
//   now_tag           : tag following the last committed entry
//   clear             : pipeline flush, held FLUSH_CYCLES cycles
//   commit_pulse/commit_pc : one-cycle retirement strobe (debug)
//   store_commit      : request to the LSB to perform the head store
//   pc_redirect_valid/pc_redirect : fetch redirect
//   halt              : simulation end
module commit_ctrl #(
    parameter int unsigned TAG_W        = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             head_valid,
    input  logic             head_done,
    input  logic [TAG_W-1:0] head_tag,
    input  logic [1:0]       head_kind,
    input  logic [4:0]       head_rd,
    input  logic [31:0]      head_val,
    input  logic [31:0]      head_pc,
    input  logic             head_mispredict,
    input  logic [31:0]      head_target,
    input  logic             store_done,
    output logic             head_pop,
    output logic             write_rdy,
    output logic [4:0]       rd,
    output logic [31:0]      write_val,
    output logic [TAG_W-1:0] now_tag,
    output logic             clear,
    output logic             commit_pulse,
    output logic [31:0]      commit_pc,
    output logic             store_commit,
    output logic             pc_redirect_valid,
    output logic [31:0]      pc_redirect,
    output logic             halt
);

    localparam int unsigned CNT_W = 3;
    localparam logic [TAG_W-1:0] TAG_FIRST = TAG_W'(1);
    localparam logic [TAG_W-1:0] TAG_LAST  = '1;

    localparam logic [1:0] KIND_REG    = 2'd0;
    localparam logic [1:0] KIND_STORE  = 2'd1;
    localparam logic [1:0] KIND_BRANCH = 2'd2;
    localparam logic [1:0] KIND_HALT   = 2'd3;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        WAIT_STORE = 2'd1,
        FLUSH      = 2'd2,
        HALTED     = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   flush_cnt, flush_cnt_nxt;
    logic               write_rdy_nxt;
    logic [4:0]         rd_nxt;
    logic [31:0]        write_val_nxt;
    logic [TAG_W-1:0]   now_tag_nxt;
    logic               clear_nxt;
    logic               commit_pulse_nxt;
    logic [31:0]        commit_pc_nxt;
    logic               store_commit_nxt;
    logic               pc_redirect_valid_nxt;
    logic [31:0]        pc_redirect_nxt;
    logic               halt_nxt;
    logic [TAG_W-1:0]   tag_after_head;

    // Tag 0 means "no dependency", so the successor of the last tag is 1.
    always_comb begin
        tag_after_head = (head_tag == TAG_LAST) ? TAG_FIRST : head_tag + TAG_W'(1);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt             = state;
        flush_cnt_nxt         = flush_cnt;
        head_pop              = 1'b0;
        write_rdy_nxt         = 1'b0;
        rd_nxt                = rd;
        write_val_nxt         = write_val;
        now_tag_nxt           = now_tag;
        clear_nxt             = clear;
        commit_pulse_nxt      = 1'b0;
        commit_pc_nxt         = commit_pc;
        store_commit_nxt      = store_commit;
        pc_redirect_valid_nxt = 1'b0;
        pc_redirect_nxt       = pc_redirect;
        halt_nxt              = halt;

        // With rdy_in low everything holds and strobes fall to 0, so a
        // strobe is never presented twice for the same retirement.
        if (rdy_in && !rst_in) begin
            unique case (state)
                RUN: begin
                    if (head_valid && head_done) begin
                        if (head_kind == KIND_STORE) begin
                            store_commit_nxt = 1'b1;
                            state_nxt        = WAIT_STORE;
                        end else begin
                            head_pop = 1'b1;
                        end
                    end
                end
                WAIT_STORE: begin
                    if (store_done) begin
                        head_pop         = 1'b1;
                        store_commit_nxt = 1'b0;
                        state_nxt        = RUN;
                    end
                end
                FLUSH: begin
                    // The ROB restarts allocation at tag 1 after a flush.
                    if (flush_cnt == '0) begin
                        clear_nxt   = 1'b0;
                        now_tag_nxt = TAG_FIRST;
                        state_nxt   = RUN;
                    end else begin
                        flush_cnt_nxt = flush_cnt - CNT_W'(1);
                    end
                end
                HALTED: begin
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase

            // Side effects common to every retirement.
            if (head_pop) begin
                commit_pulse_nxt = 1'b1;
                commit_pc_nxt    = head_pc;
                now_tag_nxt      = tag_after_head;
                if (state == RUN) begin
                    unique case (head_kind)
                        KIND_REG, KIND_BRANCH: begin
                            write_rdy_nxt = (head_rd != 5'd0);
                            rd_nxt        = head_rd;
                            write_val_nxt = head_val;
                            if (head_kind == KIND_BRANCH && head_mispredict) begin
                                pc_redirect_valid_nxt = 1'b1;
                                pc_redirect_nxt       = head_target;
                                clear_nxt             = 1'b1;
                                flush_cnt_nxt         = CNT_W'(FLUSH_CYCLES - 1);
                                state_nxt             = FLUSH;
                            end
                        end
                        KIND_HALT: begin
                            halt_nxt  = 1'b1;
                            state_nxt = HALTED;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state             <= RUN;
            flush_cnt         <= '0;
            write_rdy         <= 1'b0;
            rd                <= 5'd0;
            write_val         <= 32'd0;
            now_tag           <= TAG_FIRST;
            clear             <= 1'b0;
            commit_pulse      <= 1'b0;
            commit_pc         <= 32'd0;
            store_commit      <= 1'b0;
            pc_redirect_valid <= 1'b0;
            pc_redirect       <= 32'd0;
            halt              <= 1'b0;
        end else begin
            state             <= state_nxt;
            flush_cnt         <= flush_cnt_nxt;
            write_rdy         <= write_rdy_nxt;
            rd                <= rd_nxt;
            write_val         <= write_val_nxt;
            now_tag           <= now_tag_nxt;
            clear             <= clear_nxt;
            commit_pulse      <= commit_pulse_nxt;
            commit_pc         <= commit_pc_nxt;
            store_commit      <= store_commit_nxt;
            pc_redirect_valid <= pc_redirect_valid_nxt;
            pc_redirect       <= pc_redirect_nxt;
            halt              <= halt_nxt;
        end
    end

endmodule
